prog_clock_divider: RTL and testbench

Parametrised, runtime-programmable successor to the fixed 100 MHz slow-clock divider. It divides clk by a programmable period and produces a slow_clk with a programmable high time, plus one-cycle edge strobes for same-domain logic. New settings arrive through a valid/ready handshake. They take effect only at a period boundary, so slow_clk never glitches. It sits beside the multiplier datapath and display logic and replaces hard-coded divider constants.

---
 rtl/prog_clock_divider_pkg.sv | 17 +
 rtl/prog_clock_divider_if.sv | 17 +
 rtl/prog_clock_divider_sanitize.sv | 23 ++
 rtl/prog_clock_divider.sv | 123 ++++++++++++
 tb/tb_prog_clock_divider.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/prog_clock_divider_pkg.sv
// Shared constants and types for the programmable clock divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF = 32;

    // 100 MHz in, 400 Hz out, 50 % duty.
    localparam int unsigned DIV_DEF_100MHZ  = 250000;
    localparam int unsigned HIGH_DEF_100MHZ = 125000;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] div;
        logic [CNT_W_DEF-1:0] high;
    } div_cfg_t;

endpackage

// File: rtl/prog_clock_divider_if.sv
// Configuration handshake bundle: requester offers div/high with cfg_valid.
// Latency: n/a (wires only).
// Backpressure: cfg_ready low while an update is pending; requester holds cfg_valid.
// Ports: cfg_valid, cfg_div, cfg_high (requester -> divider), cfg_ready (divider -> requester).
interface prog_clock_divider_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;
    logic             cfg_ready;

    modport master (output cfg_valid, output cfg_div, output cfg_high, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_div, input cfg_high, output cfg_ready);
endinterface

// File: rtl/prog_clock_divider_sanitize.sv
// Clamps a requested period/high-time pair so that 1 <= high < div and div >= 2.
// Latency: combinational.
// Backpressure: none.
// Ports: div_i/high_i requested values, div_o/high_o clamped values.
module div_cfg_sanitize #(
    parameter int CNT_W = 32
) (
    input  logic [CNT_W-1:0] div_i,
    input  logic [CNT_W-1:0] high_i,
    output logic [CNT_W-1:0] div_o,
    output logic [CNT_W-1:0] high_o
);

    // Order matters: div is fixed first so the high clamp sees the final div.
    always_comb begin
        div_o  = (div_i < CNT_W'(2)) ? CNT_W'(2) : div_i;
        high_o = (high_i == '0) ? CNT_W'(1) : high_i;
        if (high_o >= div_o) begin
            high_o = div_o - CNT_W'(1);
        end
    end

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider: slow_clk with programmable period/high time plus edge strobes.
// Latency: slow_clk/count/ticks registered together; new config takes effect at the next period boundary.
// Backpressure: one config in flight; cfg_ready drops after a transfer until that config is applied.
// Ports: clk, rst (async, active-high), en, cfg (slave handshake), slow_clk, tick_rise, tick_fall, count.
module prog_clock_divider
    import clk_div_pkg::*;
#(
    parameter int               CNT_W        = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV  = CNT_W'(DIV_DEF_100MHZ),
    parameter logic [CNT_W-1:0] DEFAULT_HIGH = CNT_W'(HIGH_DEF_100MHZ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    prog_clock_divider_if.slave  cfg,
    output logic                 slow_clk,
    output logic                 tick_rise,
    output logic                 tick_fall,
    output logic [CNT_W-1:0]     count
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             slow_q, slow_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] div_a_q, div_a_d;
    logic [CNT_W-1:0] high_a_q, high_a_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;

    logic [CNT_W-1:0] san_div, san_high;
    logic [CNT_W-1:0] def_div, def_high;
    logic [CNT_W-1:0] low_d;
    logic             wrap, apply, xfer;

    div_cfg_sanitize #(.CNT_W(CNT_W)) u_cap_san (
        .div_i  (cfg.cfg_div),
        .high_i (cfg.cfg_high),
        .div_o  (san_div),
        .high_o (san_high)
    );

    // Same clamp on the reset-time values so a bad parameter can never stall slow_clk.
    div_cfg_sanitize #(.CNT_W(CNT_W)) u_def_san (
        .div_i  (DEFAULT_DIV),
        .high_i (DEFAULT_HIGH),
        .div_o  (def_div),
        .high_o (def_high)
    );

    assign cfg.cfg_ready = !pend_q;

    always_comb begin
        count_d   = count_q;
        slow_d    = slow_q;
        pend_d    = pend_q;
        div_a_d   = div_a_q;
        high_a_d  = high_a_q;
        sh_div_d  = sh_div_q;
        sh_high_d = sh_high_q;

        wrap  = (count_q == div_a_q - CNT_W'(1));
        // While idle there is no period to protect, so a pending config lands immediately.
        apply = pend_q && (!en || wrap);
        // Transfer only possible with nothing pending, so it never collides with apply.
        xfer  = cfg.cfg_valid && !pend_q;

        if (apply) begin
            div_a_d  = sh_div_q;
            high_a_d = sh_high_q;
            pend_d   = 1'b0;
        end
        if (xfer) begin
            sh_div_d  = san_div;
            sh_high_d = san_high;
            pend_d    = 1'b1;
        end

        // slow_clk is derived from the next count with the config that will be active then.
        low_d = div_a_d - high_a_d;
        if (en) begin
            count_d = wrap ? '0 : count_q + CNT_W'(1);
            slow_d  = (count_d >= low_d);
        end else begin
            count_d = '0;
            slow_d  = 1'b0;
        end

        rise_d = slow_d && !slow_q;
        fall_d = !slow_d && slow_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            slow_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            pend_q    <= 1'b0;
            div_a_q   <= def_div;
            high_a_q  <= def_high;
            sh_div_q  <= '0;
            sh_high_q <= '0;
        end else begin
            count_q   <= count_d;
            slow_q    <= slow_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pend_q    <= pend_d;
            div_a_q   <= div_a_d;
            high_a_q  <= high_a_d;
            sh_div_q  <= sh_div_d;
            sh_high_q <= sh_high_d;
        end
    end

    assign count     = count_q;
    assign slow_clk  = slow_q;
    assign tick_rise = rise_q;
    assign tick_fall = fall_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider with DEFAULT_DIV=10, DEFAULT_HIGH=5.
// Latency: n/a.
// Backpressure: n/a.
module tb_prog_clock_divider;

    int errors = 0;
    int checks = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        slow_clk, tick_rise, tick_fall;
    logic [31:0] count;

    prog_clock_divider_if #(.CNT_W(32)) cfg_if ();

    prog_clock_divider #(
        .CNT_W        (32),
        .DEFAULT_DIV  (32'd10),
        .DEFAULT_HIGH (32'd5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg       (cfg_if),
        .slow_clk  (slow_clk),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input int c, input bit s, input bit r, input bit f, input bit rdy);
        chk({tag, ".count"}, count, c);
        chk({tag, ".slow"}, {31'd0, slow_clk}, {31'd0, s});
        chk({tag, ".rise"}, {31'd0, tick_rise}, {31'd0, r});
        chk({tag, ".fall"}, {31'd0, tick_fall}, {31'd0, f});
        chk({tag, ".ready"}, {31'd0, cfg_if.cfg_ready}, {31'd0, rdy});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] d, input logic [31:0] h);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = d;
        cfg_if.cfg_high  = h;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_high  = '0;
        #2 rst = 1'b1;
        #10;
        cyc("reset", 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;

        // Default 10-cycle period: 5 low then 5 high.
        for (int k = 1; k <= 20; k++) begin
            step();
            cyc("t1", k % 10, (k % 10) >= 5, (k % 10) == 5, (k % 10) == 0, 1);
        end

        // Update mid-period: old period finishes, then 3 low / 1 high.
        step(); step(); step();
        chk("t2_pre.count", count, 3);
        offer(4, 1);
        cyc("t2_cap", 4, 0, 0, 0, 0);
        for (int k = 5; k <= 9; k++) begin
            step();
            cyc("t2_old", k, 1, k == 5, 0, 0);
        end
        step();
        cyc("t2_wrap", 0, 0, 0, 1, 1);
        for (int j = 1; j <= 8; j++) begin
            step();
            cyc("t2_new", j % 4, (j % 4) == 3, (j % 4) == 3, (j % 4) == 0, 1);
        end

        // div=0/high=0 clamps to div=2/high=1.
        offer(0, 0);
        cyc("t3_cap", 1, 0, 0, 0, 0);
        step();
        cyc("t3_a", 2, 0, 0, 0, 0);
        step();
        cyc("t3_b", 3, 1, 1, 0, 0);
        step();
        cyc("t3_wrap", 0, 0, 0, 1, 1);
        for (int j = 1; j <= 6; j++) begin
            step();
            cyc("t3_new", j % 2, (j % 2) == 1, (j % 2) == 1, (j % 2) == 0, 1);
        end

        // high >= div clamps to div-1: div=6/high=5, 1 low then 5 high.
        offer(6, 9);
        cyc("t4_cap", 1, 1, 1, 0, 0);
        step();
        cyc("t4_wrap", 0, 0, 0, 1, 1);
        for (int j = 1; j <= 12; j++) begin
            step();
            cyc("t4_new", j % 6, (j % 6) >= 1, (j % 6) == 1, (j % 6) == 0, 1);
        end

        // Drop en while high: forced fall, then restart from 0.
        step(); step();
        cyc("t5_pre", 2, 1, 0, 0, 1);
        en = 1'b0;
        step();
        cyc("t5_off", 0, 0, 0, 1, 1);
        step();
        cyc("t5_idle", 0, 0, 0, 0, 1);
        en = 1'b1;
        step();
        cyc("t5_on", 1, 1, 1, 0, 1);

        // Config offered while idle lands on the next cycle: div=3/high=1.
        en = 1'b0;
        step();
        cyc("t7_off", 0, 0, 0, 1, 1);
        offer(3, 1);
        cyc("t7_cap", 0, 0, 0, 0, 0);
        step();
        cyc("t7_apply", 0, 0, 0, 0, 1);
        en = 1'b1;
        step();
        cyc("t7_a", 1, 0, 0, 0, 1);
        step();
        cyc("t7_b", 2, 1, 1, 0, 1);
        step();
        cyc("t7_c", 0, 0, 0, 1, 1);

        // Async reset with an update pending discards it; defaults return.
        offer(8, 2);
        cyc("t6_cap", 1, 0, 0, 0, 0);
        step();
        cyc("t6_pre", 2, 1, 1, 0, 0);
        #3 rst = 1'b1;
        #1;
        cyc("t6_rst", 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_rel.count", count, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            cyc("t6_def", k % 10, (k % 10) >= 5, (k % 10) == 5, (k % 10) == 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
